// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: turns a stream of received bytes into register-file
// write/read strobes, ALU operand loads and burst writes, with an idle timeout.
module cmd_frame_decoder #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int FUNC_W   = 4,
    parameter int TIMEOUT  = 255,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_Data,
    input  logic              RX_D_VLD,
    output logic [ADDR_W-1:0] Reg_Addr,
    output logic [DATA_W-1:0] Reg_Wr_Data,
    output logic [FUNC_W-1:0] ALU_FUN,
    output logic              WrEn,
    output logic              RdEn,
    output logic              ALU_EN,
    output logic              Busy,
    output logic              Frame_Err
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUNC, BW_ADDR, BW_LEN, BW_DATA
    } state_t;

    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] TO_VAL = IDLE_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] OPA_A  = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPB_A  = ADDR_W'(OPB_ADDR);
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d, idle_inc;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [FUNC_W-1:0]   alu_fun_q, alu_fun_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                alu_en_q, alu_en_d;
    logic                busy_q;
    logic                ferr_q, ferr_d;
    logic [ADDR_W-1:0]   byte_addr;
    logic [FUNC_W-1:0]   byte_fun;

    assign byte_addr = RX_P_Data[ADDR_W-1:0];
    assign byte_fun  = RX_P_Data[FUNC_W-1:0];
    assign idle_inc  = idle_q + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            alu_fun_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            alu_fun_q  <= alu_fun_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            alu_en_q   <= alu_en_d;
            busy_q     <= (state_d != IDLE);
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        alu_fun_d  = alu_fun_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        alu_en_d   = 1'b0;
        ferr_d     = 1'b0;

        if (state_q == IDLE) begin
            idle_d = '0;
            if (RX_D_VLD) begin
                case (RX_P_Data)
                    DATA_W'(8'hAA): state_d = WR_ADDR;
                    DATA_W'(8'hBB): state_d = RD_ADDR;
                    DATA_W'(8'hCC): state_d = OPA;
                    DATA_W'(8'hDD): state_d = FUNC;
                    DATA_W'(8'hEE): state_d = BW_ADDR;
                    default:        ferr_d  = 1'b1;
                endcase
            end
        end else if (RX_D_VLD) begin
            // A strobe always wins over a timeout expiring in the same cycle.
            idle_d = '0;
            case (state_q)
                WR_ADDR: begin
                    addr_d  = byte_addr;
                    state_d = WR_DATA;
                end
                WR_DATA: begin
                    wr_en_d    = 1'b1;
                    reg_addr_d = addr_q;
                    wr_data_d  = RX_P_Data;
                    state_d    = IDLE;
                end
                RD_ADDR: begin
                    rd_en_d    = 1'b1;
                    reg_addr_d = byte_addr;
                    state_d    = IDLE;
                end
                OPA: begin
                    wr_en_d    = 1'b1;
                    reg_addr_d = OPA_A;
                    wr_data_d  = RX_P_Data;
                    state_d    = OPB;
                end
                OPB: begin
                    wr_en_d    = 1'b1;
                    reg_addr_d = OPB_A;
                    wr_data_d  = RX_P_Data;
                    state_d    = FUNC;
                end
                FUNC: begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = byte_fun;
                    state_d   = IDLE;
                end
                BW_ADDR: begin
                    addr_d  = byte_addr;
                    state_d = BW_LEN;
                end
                BW_LEN: begin
                    cnt_d   = RX_P_Data;
                    state_d = (RX_P_Data == '0) ? IDLE : BW_DATA;
                end
                BW_DATA: begin
                    wr_en_d    = 1'b1;
                    reg_addr_d = addr_q;
                    wr_data_d  = RX_P_Data;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == ONE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            idle_d = idle_inc;
            if ((TIMEOUT != 0) && (idle_inc == TO_VAL)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
                idle_d  = '0;
            end
        end
    end

    assign Reg_Addr    = reg_addr_q;
    assign Reg_Wr_Data = wr_data_q;
    assign ALU_FUN     = alu_fun_q;
    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign ALU_EN      = alu_en_q;
    assign Busy        = busy_q;
    assign Frame_Err   = ferr_q;

endmodule
